ebus_arbiter: RTL

- Sequences EBOX-side EBUS transactions (CONO/CONI/DATAO/DATAI) and PI-side interrupt function cycles onto the single shared EBUS.
- Sits between the APR/CON EBUS request logic and the PI, and the backplane EBUS drivers.
- Arbitrates between the two requesters, drives controller-select, function and demand, and handles the device transfer handshake with timeout and non-existent-device (NXD) reporting.

---
 rtl/ebus_arbiter.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/ebus_arbiter.sv
`timescale 1ns/1ps
// ebus_arbiter
// Sequences EBOX-side EBUS transactions (CONO/CONI/DATAO/DATAI) and PI-side
// interrupt function cycles onto the single shared EBUS.
//
// Ports:
//   clk, RESET                    clock, asynchronous active-high reset
//   ebox_req/func/cs/wdata        EBOX request (held until ebox_done)
//   ebox_done/rdata/nxd           EBOX completion pulse, read data, timeout flag
//   pi_req/func/cs                PI function request (always a read)
//   pi_done/rdata/nxd             PI completion pulse, read data, timeout flag
//   ebus_cs/func/demand           registered EBUS controller select, function, demand
//   ebus_data_oe/data_out         EBUS write-data driver enable and data
//   ebus_xfer, ebus_data_in       device transfer acknowledge and read data
//   busy                          a transaction is in progress
//
// A transaction walks IDLE -> SETUP -> DEMAND -> RELEASE -> IDLE. SETUP gives
// the bus SETUP cycles of settled cs/func/data before demand; DEMAND waits for
// the device to raise xfer; RELEASE waits for it to drop xfer. Both waits are
// bounded by TIMEOUT and report a non-existent device through the nxd flag.
module ebus_arbiter #(
  parameter int unsigned SETUP   = 2,   // 1..7
  parameter int unsigned TIMEOUT = 63   // 1..255
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        ebox_req,
  input  logic [2:0]  ebox_func,
  input  logic [6:0]  ebox_cs,
  input  logic [35:0] ebox_wdata,
  output logic        ebox_done,
  output logic [35:0] ebox_rdata,
  output logic        ebox_nxd,
  input  logic        pi_req,
  input  logic [2:0]  pi_func,
  input  logic [6:0]  pi_cs,
  output logic        pi_done,
  output logic [35:0] pi_rdata,
  output logic        pi_nxd,
  output logic [6:0]  ebus_cs,
  output logic [2:0]  ebus_func,
  output logic        ebus_demand,
  output logic        ebus_data_oe,
  output logic [35:0] ebus_data_out,
  input  logic        ebus_xfer,
  input  logic [35:0] ebus_data_in,
  output logic        busy
);

  localparam logic [7:0] SetupLast  = 8'(SETUP - 1);
  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StSetup, StDemand, StRelease} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  // last_pi_q also identifies the owner of the transaction in flight.
  logic        last_pi_q, last_pi_d;
  logic        wr_q, wr_d;
  logic [6:0]  cs_q, cs_d;
  logic [2:0]  func_q, func_d;
  logic        demand_q, demand_d;
  logic        oe_q, oe_d;
  logic [35:0] dout_q, dout_d;
  logic        ebox_done_q, ebox_done_d;
  logic        pi_done_q, pi_done_d;
  logic [35:0] ebox_rdata_q, ebox_rdata_d;
  logic [35:0] pi_rdata_q, pi_rdata_d;
  logic        ebox_nxd_q, ebox_nxd_d;
  logic        pi_nxd_q, pi_nxd_d;

  logic ebox_elig, pi_elig, grant_pi, grant_ebox, ebox_is_wr;

  // A requester still holding req during its own done cycle is not asking again.
  assign ebox_elig  = ebox_req & ~ebox_done_q;
  assign pi_elig    = pi_req & ~pi_done_q;
  assign grant_pi   = pi_elig & (~ebox_elig | ~last_pi_q);
  assign grant_ebox = ebox_elig & ~grant_pi;
  assign ebox_is_wr = (ebox_func == 3'b000) || (ebox_func == 3'b010);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_pi_d    = last_pi_q;
    wr_d         = wr_q;
    cs_d         = cs_q;
    func_d       = func_q;
    demand_d     = demand_q;
    oe_d         = oe_q;
    dout_d       = dout_q;
    ebox_done_d  = 1'b0;
    pi_done_d    = 1'b0;
    ebox_rdata_d = ebox_rdata_q;
    pi_rdata_d   = pi_rdata_q;
    ebox_nxd_d   = ebox_nxd_q;
    pi_nxd_d     = pi_nxd_q;

    unique case (state_q)
      StIdle: begin
        if (grant_pi) begin
          cs_d      = pi_cs;
          func_d    = pi_func;
          wr_d      = 1'b0;
          oe_d      = 1'b0;
          dout_d    = '0;
          pi_nxd_d  = 1'b0;
          last_pi_d = 1'b1;
          cnt_d     = '0;
          state_d   = StSetup;
        end else if (grant_ebox) begin
          cs_d       = ebox_cs;
          func_d     = ebox_func;
          wr_d       = ebox_is_wr;
          oe_d       = ebox_is_wr;
          dout_d     = ebox_is_wr ? ebox_wdata : '0;
          ebox_nxd_d = 1'b0;
          last_pi_d  = 1'b0;
          cnt_d      = '0;
          state_d    = StSetup;
        end
      end

      StSetup: begin
        if (cnt_q == SetupLast) begin
          cnt_d    = '0;
          demand_d = 1'b1;
          state_d  = StDemand;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StDemand: begin
        if (ebus_xfer) begin
          // xfer wins over a simultaneous timeout.
          if (!wr_q) begin
            if (last_pi_q) pi_rdata_d = ebus_data_in;
            else           ebox_rdata_d = ebus_data_in;
          end
          cnt_d    = '0;
          demand_d = 1'b0;
          state_d  = StRelease;
        end else if (cnt_q == TimeoutCnt) begin
          if (last_pi_q) begin
            pi_nxd_d   = 1'b1;
            pi_rdata_d = '0;
          end else begin
            ebox_nxd_d   = 1'b1;
            ebox_rdata_d = '0;
          end
          cnt_d    = '0;
          demand_d = 1'b0;
          state_d  = StRelease;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StRelease: begin
        if (!ebus_xfer || (cnt_q == TimeoutCnt)) begin
          // Device still holding xfer at the timeout counts as non-existent.
          if (ebus_xfer) begin
            if (last_pi_q) pi_nxd_d = 1'b1;
            else           ebox_nxd_d = 1'b1;
          end
          if (last_pi_q) pi_done_d = 1'b1;
          else           ebox_done_d = 1'b1;
          cs_d    = '0;
          func_d  = '0;
          wr_d    = 1'b0;
          oe_d    = 1'b0;
          dout_d  = '0;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_pi_q    <= 1'b0;
      wr_q         <= 1'b0;
      cs_q         <= '0;
      func_q       <= '0;
      demand_q     <= 1'b0;
      oe_q         <= 1'b0;
      dout_q       <= '0;
      ebox_done_q  <= 1'b0;
      pi_done_q    <= 1'b0;
      ebox_rdata_q <= '0;
      pi_rdata_q   <= '0;
      ebox_nxd_q   <= 1'b0;
      pi_nxd_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_pi_q    <= last_pi_d;
      wr_q         <= wr_d;
      cs_q         <= cs_d;
      func_q       <= func_d;
      demand_q     <= demand_d;
      oe_q         <= oe_d;
      dout_q       <= dout_d;
      ebox_done_q  <= ebox_done_d;
      pi_done_q    <= pi_done_d;
      ebox_rdata_q <= ebox_rdata_d;
      pi_rdata_q   <= pi_rdata_d;
      ebox_nxd_q   <= ebox_nxd_d;
      pi_nxd_q     <= pi_nxd_d;
    end
  end

  assign ebox_done     = ebox_done_q;
  assign ebox_rdata    = ebox_rdata_q;
  assign ebox_nxd      = ebox_nxd_q;
  assign pi_done       = pi_done_q;
  assign pi_rdata      = pi_rdata_q;
  assign pi_nxd        = pi_nxd_q;
  assign ebus_cs       = cs_q;
  assign ebus_func     = func_q;
  assign ebus_demand   = demand_q;
  assign ebus_data_oe  = oe_q;
  assign ebus_data_out = dout_q;
  assign busy          = (state_q != StIdle);

  a_done_excl : assert property (@(posedge clk) disable iff (RESET)
    !(ebox_done_q && pi_done_q));
  a_done_no_demand : assert property (@(posedge clk) disable iff (RESET)
    !((ebox_done_q || pi_done_q) && demand_q));

endmodule
